// File: rtl/gcore_pkg.sv
// Shared GCore definitions: opcode values, instruction field layout and the
// fetch-stage state encoding.
package gcore_pkg;

  localparam int OP_W    = 4;
  localparam int OPND_W  = 12;
  localparam int INSTR_W = 16;
  localparam int OP_LSB  = OPND_W;

  localparam logic [OP_W-1:0] OP_NOP   = 4'h0;
  localparam logic [OP_W-1:0] OP_JUMP  = 4'h1;
  localparam logic [OP_W-1:0] OP_SAVE  = 4'h2;
  localparam logic [OP_W-1:0] OP_LOAD  = 4'h3;
  localparam logic [OP_W-1:0] OP_LOADI = 4'h4;
  localparam logic [OP_W-1:0] OP_SLL   = 4'h5;
  localparam logic [OP_W-1:0] OP_ADD   = 4'h6;
  localparam logic [OP_W-1:0] OP_SUB   = 4'h7;
  localparam logic [OP_W-1:0] OP_AND   = 4'h8;
  localparam logic [OP_W-1:0] OP_OR    = 4'h9;
  localparam logic [OP_W-1:0] OP_XOR   = 4'hA;
  localparam logic [OP_W-1:0] OP_SRL   = 4'hB;
  localparam logic [OP_W-1:0] OP_NOT   = 4'hC;
  localparam logic [OP_W-1:0] OP_INC   = 4'hD;
  localparam logic [OP_W-1:0] OP_DEC   = 4'hE;
  localparam logic [OP_W-1:0] OP_BZ    = 4'hF;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_ISSUE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// GCore instruction fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction for decode/execute and picks the next PC on retire.
module fetch_unit
  import gcore_pkg::*;
#(
  parameter int AW       = 12,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [AW-1:0]      imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [OP_W-1:0]    op,
  output logic [OPND_W-1:0]  operand,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump,
  input  logic               branch,
  input  logic               acc_zero,
  output logic [AW-1:0]      pc,
  output logic [15:0]        icount
);

  localparam logic [AW-1:0] RESET_ADDR = AW'(RESET_PC);

  fetch_state_t       state, state_next;
  logic [AW-1:0]      pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic [15:0]        icount_q;
  logic               retire;
  logic               take;

  assign retire = (state == FS_ISSUE) && instr_ready;
  assign take   = jump || (branch && acc_zero);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_BOOT;
    else        state <= state_next;
  end

  // NOTE: state_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      FS_BOOT:  state_next = FS_FETCH;
      FS_FETCH: if (imem_ack) state_next = FS_ISSUE;
      FS_ISSUE: if (instr_ready) state_next = FS_FETCH;
      default:  state_next = FS_BOOT;
    endcase
  end

  // Jump/branch targets use only the low AW bits of the operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_ADDR;
      ir_q     <= '0;
      icount_q <= '0;
    end else begin
      if ((state == FS_FETCH) && imem_ack) ir_q <= imem_rdata;
      if (retire) begin
        pc_q     <= take ? ir_q[AW-1:0] : pc_q + AW'(1);
        icount_q <= icount_q + 16'd1;
      end
    end
  end

  // Every output is a register or a decode of the state register alone.
  assign imem_req    = (state == FS_FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state == FS_ISSUE);
  assign op          = instr_valid ? ir_q[INSTR_W-1:OP_LSB] : OP_NOP;
  assign operand     = instr_valid ? ir_q[OPND_W-1:0] : '0;
  assign pc          = pc_q;
  assign icount      = icount_q;

endmodule
